// File: rtl/multicycle_ctr_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctr_pkg
// Shared definitions for the multi-cycle main controller: MIPS-subset opcode
// constants, the FSM state encoding, datapath select encodings and the
// one-hot opcode class produced by the decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package multicycle_ctr_pkg;

    // IR[31:26] values recognised by the controller
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_EXEC,
        ST_ALUWB,
        ST_ADDIEX,
        ST_ADDIWB,
        ST_BRANCH,
        ST_JUMP,
        ST_TRAP
    } state_t;

    // Second ALU operand select
    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    // ALU operation class handed to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // Next-PC source select
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_source_t;

    // One-hot instruction class; exactly one field is set for any opcode
    typedef struct packed {
        logic mem;
        logic rtype;
        logic branch;
        logic jump;
        logic addi;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_ctr_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctr_if
// Bundle between the multi-cycle controller and its datapath.
//   opcode, mem_ready          : datapath -> controller
//   PCWrite .. ALUSrcA         : 1-bit strobes/selects, controller -> datapath
//   ALUSrcB, ALUOp, PCSource   : 2-bit selects, controller -> datapath
//   instr_done, illegal_op     : status, controller -> datapath
// Modports: master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface multicycle_ctr_if;
    import multicycle_ctr_pkg::*;

    logic [5:0] opcode;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       BranchNe;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       ALUSrcA;
    alu_src_b_t ALUSrcB;
    alu_op_t    ALUOp;
    pc_source_t PCSource;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
               MemToReg, IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
               MemToReg, IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, illegal_op
    );

endinterface

// File: rtl/multicycle_ctr_opcode_class.sv
// -----------------------------------------------------------------------------
// opcode_class
// Combinational opcode classifier feeding the controller's DECODE dispatch.
//   opcode   in  6  IR[31:26]
//   op_class out    one-hot {mem, rtype, branch, jump, addi, illegal}
// EXT_OPS = 0 turns addi and bne into illegal opcodes.
// -----------------------------------------------------------------------------
module opcode_class
    import multicycle_ctr_pkg::*;
#(
    parameter bit EXT_OPS = 1'b1
) (
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a bit unassigned, which would otherwise infer a latch.
        op_class = '0;
        case (opcode)
            OP_LW, OP_SW: op_class.mem    = 1'b1;
            OP_R:         op_class.rtype  = 1'b1;
            OP_BEQ:       op_class.branch = 1'b1;
            OP_J:         op_class.jump   = 1'b1;
            OP_ADDI: begin
                if (EXT_OPS) op_class.addi    = 1'b1;
                else         op_class.illegal = 1'b1;
            end
            OP_BNE: begin
                if (EXT_OPS) op_class.branch  = 1'b1;
                else         op_class.illegal = 1'b1;
            end
            default:      op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctr.sv
// -----------------------------------------------------------------------------
// multicycle_ctr
// Multi-cycle main controller: sequences one MIPS-subset instruction over
// 3-5 cycles (plus memory wait cycles) and drives the shared-ALU /
// shared-memory datapath's control lines.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    master side of multicycle_ctr_if (opcode, mem_ready in;
//          datapath controls, instr_done, illegal_op out)
// Parameters:
//   MEM_HANDSHAKE  1 = FETCH/MEMRD/MEMWR wait for mem_ready, 0 = never wait
//   EXT_OPS        1 = addi and bne decoded, 0 = they trap
// Outputs decode the registered state; FETCH IRWrite/PCWrite and MEMWR
// instr_done additionally follow mem_ready within the cycle.
// -----------------------------------------------------------------------------
module multicycle_ctr
    import multicycle_ctr_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit EXT_OPS       = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctr_if.master  bus
);

    state_t    state;
    state_t    state_next;
    op_class_t op_class;
    logic      ready;

    // Without the handshake every memory access is assumed to complete at once
    assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    opcode_class #(
        .EXT_OPS (EXT_OPS)
    ) u_opcode_class (
        .opcode   (bus.opcode),
        .op_class (op_class)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next      = state;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.BranchNe    = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = SRCB_REG;
        bus.ALUOp       = ALUOP_ADD;
        bus.PCSource    = PCSRC_ALU;
        bus.instr_done  = 1'b0;
        bus.illegal_op  = 1'b0;

        case (state)
            ST_IDLE: state_next = ST_FETCH;

            ST_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed,
                // together with the IR load, when memory delivers the word
                bus.MemRead = 1'b1;
                bus.ALUSrcB = SRCB_FOUR;
                bus.IRWrite = ready;
                bus.PCWrite = ready;
                if (ready) state_next = ST_DECODE;
            end

            ST_DECODE: begin
                // Speculative branch target into ALUOut while dispatching
                bus.ALUSrcB = SRCB_IMM_SH2;
                if      (op_class.mem)    state_next = ST_MEMADR;
                else if (op_class.rtype)  state_next = ST_EXEC;
                else if (op_class.branch) state_next = ST_BRANCH;
                else if (op_class.jump)   state_next = ST_JUMP;
                else if (op_class.addi)   state_next = ST_ADDIEX;
                else                      state_next = ST_TRAP;
            end

            ST_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                state_next  = (bus.opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end

            ST_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (ready) state_next = ST_MEMWB;
            end

            ST_MEMWB: begin
                bus.MemToReg   = 1'b1;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = ST_FETCH;
            end

            ST_MEMWR: begin
                bus.MemWrite   = 1'b1;
                bus.IorD       = 1'b1;
                bus.instr_done = ready;
                if (ready) state_next = ST_FETCH;
            end

            ST_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALUOP_FUNCT;
                state_next  = ST_ALUWB;
            end

            ST_ALUWB: begin
                bus.RegDst     = 1'b1;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = ST_FETCH;
            end

            ST_ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                state_next  = ST_ADDIWB;
            end

            ST_ADDIWB: begin
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = ST_FETCH;
            end

            ST_BRANCH: begin
                // beq and bne differ only in opcode bit 0, which selects the
                // sense of the zero flag in the datapath's PC enable
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = ALUOP_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = PCSRC_ALUOUT;
                bus.BranchNe    = bus.opcode[0];
                bus.instr_done  = 1'b1;
                state_next      = ST_FETCH;
            end

            ST_JUMP: begin
                bus.PCWrite    = 1'b1;
                bus.PCSource   = PCSRC_JUMP;
                bus.instr_done = 1'b1;
                state_next     = ST_FETCH;
            end

            // Absorbing: only reset leaves TRAP
            ST_TRAP: bus.illegal_op = 1'b1;

            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: doc/multicycle_ctr.md
# multicycle_ctr

Multi-cycle successor to the single-cycle main control decoder: a Moore/Mealy FSM that sequences one MIPS-subset instruction over 3–5 cycles and drives the shared-ALU/shared-memory datapath's control lines. It sits between the instruction register's opcode field and the multi-cycle datapath. It adds a memory-ready handshake, optional extended ops (addi, bne), an illegal-opcode trap and a per-instruction completion pulse.

## Interface
- `MEM_HANDSHAKE`, 1: 1 = FETCH/MEMRD/MEMWR wait for `mem_ready`; 0 = `mem_ready` ignored (treated as 1).
- `EXT_OPS`, 1: 1 = addi (001000) and bne (000101) decoded; 0 = both trap as illegal.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26], stable from DECODE until the instruction ends.
- `mem_ready`  in  1  memory completed the current access this cycle.
- `PCWrite`, `PCWriteCond`, `BranchNe`, `IorD`, `MemRead`, `MemWrite`, `MemToReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each  datapath strobes/selects.
- `ALUSrcB`  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- `ALUOp`  out  2  00 add, 01 sub, 10 funct-decoded.
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction.
- `illegal_op`  out  1  high while in TRAP.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP.
- Outputs not listed for a state are 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, ALUSrcB=01. IRWrite=PCWrite=mem_ready (Mealy). Stay in FETCH while !mem_ready, else go to DECODE.
- DECODE: ALUSrcB=11. Dispatch on opcode:
  - 100011 or 101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX (if EXT_OPS)
  - 000101 → BRANCH (if EXT_OPS)
  - anything else → TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10. lw → MEMRD; sw → MEMWR.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then MEMWB.
- MEMWB: MemToReg=1, RegWrite=1. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Wait for mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUOp=10. Next state ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next state ADDIWB.
- ADDIWB: RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNe=opcode[0]. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- TRAP: illegal_op=1, all strobes 0. Absorbing; only reset leaves it.
- instr_done=1 in: MEMWB, MEMWR with mem_ready, ALUWB, ADDIWB, BRANCH, JUMP.

## Timing
- Reset asserted: state=IDLE immediately (async); every output 0.
- First FETCH is the cycle after rst_n deasserts.
- Cycle counts with mem_ready constantly 1: lw 5; sw, R-type, addi 4; beq, bne, j 3.
- Each cycle mem_ready is low adds one cycle in FETCH/MEMRD/MEMWR. No timeout.
- All outputs are combinational from the registered state. FETCH IRWrite/PCWrite and MEMWR instr_done also depend combinationally on mem_ready.
- MEM_HANDSHAKE=0: the three wait states always advance after one cycle.
- Reset mid-instruction: the instruction is abandoned and no strobe is produced after reset assertion.
- Opcode changes outside DECODE..end of instruction are ignored; the FSM samples opcode only in DECODE, MEMADR and BRANCH.

## Structure
- Package `multicycle_ctr_pkg`:
  - 6-bit opcode constants OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI.
  - State enum (4-bit).
  - ALUSrcB, ALUOp and PCSource encodings.
- Sub-module `opcode_class`: combinational; maps opcode plus EXT_OPS to a one-hot class {mem, rtype, branch, jump, addi, illegal}. The FSM's DECODE dispatch consumes it.
- FSM is a two-process implementation: a state register and a next-state/output decode.

## Test plan
- Reset, then opcode=000000 with mem_ready=1 → states IDLE, FETCH, DECODE, EXEC, ALUWB; RegDst=RegWrite=1 only in ALUWB; instr_done pulses once; 4 cycles from FETCH.
- lw (100011) with mem_ready low 2 cycles in FETCH and 3 in MEMRD → IRWrite only on the ready cycle; MemToReg=1 in MEMWB; 10 cycles total.
- beq (000100) then bne (000101) → PCWriteCond=1, PCSource=01 in BRANCH; BranchNe=0 then 1; 3 cycles each.
- EXT_OPS=0, opcode=001000 → TRAP after DECODE; illegal_op=1 held 20 cycles; no RegWrite/MemWrite; rst_n low clears it to IDLE.
- sw (101011) with rst_n pulsed low during MEMWR → MemWrite drops to 0 within the reset cycle; restart begins at FETCH.
- MEM_HANDSHAKE=1 vs 0, j (000010) with mem_ready=0 → MEM_HANDSHAKE=1 stalls in FETCH; MEM_HANDSHAKE=0 completes in 3 cycles with PCSource=10.
